irq_entry_unit: RTL and testbench

Sequential interrupt entry/exit unit between the combinational priority encoder (`irq`, `irq_vec`) and the CPU core's fetch stage. It holds the global interrupt enable and waits for an instruction boundary before taking a request. On entry it saves the PC, produces the vector address and acknowledges the source. On `reti` it restores PC and enable state.

---
 rtl/irq_entry_unit_if.sv | 30 +++
 rtl/irq_entry_unit.sv | 163 ++++++++++++++++
 tb/tb_irq_entry_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_entry_unit_if.sv
// irq_entry_unit_if: bundle between the priority encoder/core and the
// interrupt entry unit. The master side is the core plus the encoder. The
// slave side is the entry unit itself.
interface irq_entry_unit_if;
  logic       irq;
  logic [2:0] irq_vec;
  logic       ie_set;
  logic       ie_clr;
  logic       instr_boundary;
  logic [7:0] pc;
  logic       reti;
  logic       take_irq;
  logic [7:0] vec_addr;
  logic [2:0] irq_ack;
  logic       ret_valid;
  logic [7:0] ret_pc;
  logic       in_isr;
  logic       ie;
  logic [2:0] active_vec;

  modport master (
    output irq, irq_vec, ie_set, ie_clr, instr_boundary, pc, reti,
    input  take_irq, vec_addr, irq_ack, ret_valid, ret_pc, in_isr, ie, active_vec
  );

  modport slave (
    input  irq, irq_vec, ie_set, ie_clr, instr_boundary, pc, reti,
    output take_irq, vec_addr, irq_ack, ret_valid, ret_pc, in_isr, ie, active_vec
  );
endinterface

// File: rtl/irq_entry_unit.sv
// irq_entry_unit: interrupt entry/exit sequencer. It holds the global enable,
// waits for an instruction boundary before redirecting fetch, and keeps a
// context stack of {pc, source, ie} for RETI.
// Optional feature macro IRQ_NEST_EN: enables nesting of strictly
// higher-priority sources (stack depth 3). Without it, the stack depth is 1.
// Priority: the lower bit of irq_vec wins (timer > uart_rx > ext).
module irq_entry_unit #(
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter logic [7:0] VEC_STRIDE = 8'd4
) (
  input logic          clk,
  input logic          rst_n,
  irq_entry_unit_if.slave bus
);

`ifdef IRQ_NEST_EN
  localparam int DEPTH = 3;
  localparam bit NEST  = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit NEST  = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PEND, ISR} state_t;

  state_t     state, state_nx;
  logic [7:0] stk_pc  [DEPTH];
  logic [2:0] stk_vec [DEPTH];
  logic       stk_ie  [DEPTH];
  logic [1:0] sp;
  logic       ie_q;
  logic [2:0] pend_vec, pend_vec_nx;
  logic       valid_req, prio_ok, takeable, in_isr;
  logic       entry, pop;

  // The stack top always lives in entry 0, so the innermost ISR is stk_*[0].
  // When nesting is enabled, a request must strictly outrank the active source.
  always_comb begin
    in_isr    = (sp != 2'd0);
    valid_req = bus.irq && (bus.irq_vec == 3'b001 || bus.irq_vec == 3'b010 ||
                            bus.irq_vec == 3'b100);
    prio_ok   = in_isr ? (NEST && (bus.irq_vec < stk_vec[0])) : 1'b1;
    takeable  = valid_req && ie_q && prio_ok;
  end

  // Next state. A RETI is always served before any pending request.
  always_comb begin
    state_nx    = state;
    pend_vec_nx = pend_vec;
    entry       = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (takeable) begin
          state_nx    = PEND;
          pend_vec_nx = bus.irq_vec;
        end
      end
      PEND: begin
        if (in_isr && bus.reti) begin
          pop      = 1'b1;
          state_nx = (sp == 2'd1) ? IDLE : ISR;
        end else if (!takeable) begin
          state_nx = in_isr ? ISR : IDLE;
        end else begin
          pend_vec_nx = bus.irq_vec;
          if (bus.instr_boundary) begin
            entry    = 1'b1;
            state_nx = ISR;
          end
        end
      end
      ISR: begin
        if (bus.reti) begin
          pop      = 1'b1;
          state_nx = (sp == 2'd1) ? IDLE : ISR;
        end else if (takeable) begin
          state_nx    = PEND;
          pend_vec_nx = bus.irq_vec;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and the pending source, which follows irq_vec while it waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_vec <= 3'b000;
    end else begin
      state    <= state_nx;
      pend_vec <= pend_vec_nx;
    end
  end

  // Global enable: entry clears, RETI restores, then DI beats EI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= 1'b0;
    end else if (entry) begin
      ie_q <= 1'b0;
    end else if (pop) begin
      ie_q <= stk_ie[0];
    end else if (bus.ie_clr) begin
      ie_q <= 1'b0;
    end else if (bus.ie_set) begin
      ie_q <= 1'b1;
    end
  end

  // Context stack as a shift register: push shifts down, pop shifts up and zero-fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_pc[i]  <= 8'h00;
        stk_vec[i] <= 3'b000;
        stk_ie[i]  <= 1'b0;
      end
    end else if (entry) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stk_pc[i]  <= stk_pc[i-1];
        stk_vec[i] <= stk_vec[i-1];
        stk_ie[i]  <= stk_ie[i-1];
      end
      stk_pc[0]  <= bus.pc;
      stk_vec[0] <= pend_vec;
      stk_ie[0]  <= ie_q;
      sp         <= sp + 2'd1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stk_pc[i]  <= stk_pc[i+1];
        stk_vec[i] <= stk_vec[i+1];
        stk_ie[i]  <= stk_ie[i+1];
      end
      stk_pc[DEPTH-1]  <= 8'h00;
      stk_vec[DEPTH-1] <= 3'b000;
      stk_ie[DEPTH-1]  <= 1'b0;
      sp               <= sp - 2'd1;
    end
  end

  // Output decode. The pulses are zero outside the entry and return cycles.
  always_comb begin
    bus.take_irq   = entry;
    bus.irq_ack    = entry ? pend_vec : 3'b000;
    bus.ret_valid  = pop;
    bus.ret_pc     = pop ? stk_pc[0] : 8'h00;
    bus.in_isr     = in_isr;
    bus.ie         = ie_q;
    bus.active_vec = stk_vec[0];
    bus.vec_addr   = 8'h00;
    if (entry) begin
      case (pend_vec)
        3'b010:  bus.vec_addr = VEC_BASE + VEC_STRIDE;
        3'b100:  bus.vec_addr = VEC_BASE + {VEC_STRIDE[6:0], 1'b0};
        default: bus.vec_addr = VEC_BASE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_entry_unit.sv
// tb_irq_entry_unit: self-checking bench for irq_entry_unit. It uses a vector
// table, hand-written multi-cycle sequences and random stimulus against a
// queue-based reference model. It follows IRQ_NEST_EN like the design.
module tb_irq_entry_unit;

`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  irq_entry_unit_if bus ();

  irq_entry_unit #(.VEC_BASE(8'hF0), .VEC_STRIDE(8'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       irq;
    logic [2:0] vec;
    logic       set;
    logic       clr;
    logic       bnd;
    logic [7:0] pc;
    logic       reti;
    logic       take;
    logic [7:0] addr;
    logic [2:0] ack;
    logic       ret;
    logic [7:0] rpc;
    logic       ie;
    logic       isr;
    logic [2:0] act;
  } vec_row_t;

  typedef struct {
    logic [7:0] pc;
    int         src;
    logic       ie;
  } frame_t;

  vec_row_t tbl[$];

  // reference model: a queue of saved contexts plus a pending flag
  frame_t     m_stk[$];
  logic       m_ie;
  bit         m_pend;
  int         m_src;
  bit         m_can;
  int         m_new_src;
  logic       e_take, e_ret, e_ie, e_isr;
  logic [7:0] e_addr, e_rpc;
  logic [2:0] e_ack, e_act;

  function automatic vec_row_t mk(
    input logic irq, input logic [2:0] vec, input logic set, input logic clr,
    input logic bnd, input logic [7:0] pc, input logic reti,
    input logic take, input logic [7:0] addr, input logic [2:0] ack,
    input logic ret, input logic [7:0] rpc, input logic ie, input logic isr,
    input logic [2:0] act);
    vec_row_t r;
    r = '{irq, vec, set, clr, bnd, pc, reti, take, addr, ack, ret, rpc, ie, isr, act};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic take, input logic [7:0] addr,
                          input logic [2:0] ack, input logic ret, input logic [7:0] rpc,
                          input logic ie, input logic isr, input logic [2:0] act);
    checkOutput({tag, " take_irq"}, bus.take_irq, take);
    checkOutput({tag, " vec_addr"}, bus.vec_addr, addr);
    checkOutput({tag, " irq_ack"}, bus.irq_ack, ack);
    checkOutput({tag, " ret_valid"}, bus.ret_valid, ret);
    checkOutput({tag, " ret_pc"}, bus.ret_pc, rpc);
    checkOutput({tag, " ie"}, bus.ie, ie);
    checkOutput({tag, " in_isr"}, bus.in_isr, isr);
    checkOutput({tag, " active_vec"}, bus.active_vec, act);
  endtask

  task automatic clearInputs;
    bus.irq = 1'b0; bus.irq_vec = 3'b000; bus.ie_set = 1'b0; bus.ie_clr = 1'b0;
    bus.instr_boundary = 1'b0; bus.pc = 8'h00; bus.reti = 1'b0;
  endtask

  task automatic applyStimulus(input vec_row_t r);
    @(negedge clk);
    bus.irq = r.irq; bus.irq_vec = r.vec; bus.ie_set = r.set; bus.ie_clr = r.clr;
    bus.instr_boundary = r.bnd; bus.pc = r.pc; bus.reti = r.reti;
    #1;
  endtask

  task automatic resetDut;
    @(negedge clk);
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // steps whole cycles until take_irq is seen; lat = cycles waited, -1 if never
  task automatic waitTake(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k <= budget; k++) begin
      if (bus.take_irq === 1'b1) begin
        lat = k;
        return;
      end
      if (k < budget) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic modelReset;
    m_stk.delete();
    m_ie = 1'b0;
    m_pend = 1'b0;
    m_src = 0;
  endtask

  task automatic modelEval(input logic irq, input logic [2:0] vec, input logic bnd, input logic reti);
    int top_src;
    m_new_src = -1;
    if (vec == 3'b001) m_new_src = 0;
    else if (vec == 3'b010) m_new_src = 1;
    else if (vec == 3'b100) m_new_src = 2;
    top_src = (m_stk.size() > 0) ? m_stk[$].src : 3;
    m_can = irq && (m_new_src >= 0) && m_ie &&
            (m_stk.size() == 0 || (NEST && m_new_src < top_src));
    e_ret  = reti && (m_stk.size() > 0);
    e_take = m_pend && m_can && bnd && !e_ret;
    e_addr = e_take ? 8'(240 + 4 * m_src) : 8'h00;
    e_ack  = e_take ? 3'(1 << m_src) : 3'b000;
    e_rpc  = e_ret ? m_stk[$].pc : 8'h00;
    e_ie   = m_ie;
    e_isr  = (m_stk.size() > 0);
    e_act  = (m_stk.size() > 0) ? 3'(1 << top_src) : 3'b000;
  endtask

  task automatic modelUpdate(input logic set, input logic clr, input logic [7:0] pc);
    frame_t f;
    if (e_ret) begin
      m_ie = m_stk[$].ie;
      void'(m_stk.pop_back());
      m_pend = 1'b0;
    end else if (e_take) begin
      f.pc = pc; f.src = m_src; f.ie = m_ie;
      m_stk.push_back(f);
      m_ie = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (clr) m_ie = 1'b0;
      else if (set) m_ie = 1'b1;
      m_pend = m_can;
      if (m_can) m_src = m_new_src;
    end
  endtask

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int lat;
    logic [2:0] prev_vec;
    logic r_irq, r_set, r_clr, r_bnd, r_reti;
    logic [2:0] r_vec;
    logic [7:0] r_pc;
    int rr;

    // irq, vec, set, clr, bnd, pc, reti | take, addr, ack, ret, rpc, ie, isr, act
    tbl.push_back(mk(0, 3'b000, 1, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h23, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h23, 0,  1, 8'hF0, 3'b001, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h50, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b001));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h50, 1,  0, 8'h00, 3'b000, 1, 8'h23, 0, 1, 3'b001));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b000, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b000, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b011, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b011, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 1,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 1, 1, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 1, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(1, 3'b100, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b010, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b010, 0, 0, 1, 8'h77, 0,  1, 8'hF4, 3'b010, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b010));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 1,  0, 8'h00, 3'b000, 1, 8'h77, 0, 1, 3'b010));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 1, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 1, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(1, 3'b100, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b100, 1, 0, 1, 8'h9A, 0,  1, 8'hF8, 3'b100, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b100));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 1,  0, 8'h00, 3'b000, 1, 8'h9A, 0, 1, 3'b100));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h11, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(1, 3'b001, 0, 0, 1, 8'h11, 0,  1, 8'hF0, 3'b001, 0, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(0, 3'b000, 1, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b001));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 1,  0, 8'h00, 3'b000, 1, 8'h11, 1, 1, 3'b001));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 8'h00, 0,  0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000));

    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkAll("reset", 0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table: %0d rows", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkAll($sformatf("row%0d", i), tbl[i].take, tbl[i].addr, tbl[i].ack, tbl[i].ret,
               tbl[i].rpc, tbl[i].ie, tbl[i].isr, tbl[i].act);
    end

    // ie=0 with ext held: nothing is taken until EI, then entry one cycle after registration
    $display("[TB] sequence: ext held with ie=0");
    resetDut();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.irq = 1'b1; bus.irq_vec = 3'b100; bus.instr_boundary = 1'b1; bus.pc = 8'h3C;
      #1;
      checkOutput($sformatf("ie0 hold c%0d take_irq", c), bus.take_irq, 1'b0);
    end
    @(negedge clk);
    bus.ie_set = 1'b1;
    #1;
    checkOutput("ei cycle take_irq", bus.take_irq, 1'b0);
    @(negedge clk);
    bus.ie_set = 1'b0;
    #1;
    waitTake(6, lat);
    checkOutput("ei latency", lat, 1);
    checkOutput("ei vec_addr", bus.vec_addr, 8'hF8);
    checkOutput("ei irq_ack", bus.irq_ack, 3'b100);
    @(negedge clk);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;
    #1;
    checkAll("ext isr", 0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b100);
    @(negedge clk);
    bus.reti = 1'b1;
    #1;
    checkAll("ext reti", 0, 8'h00, 3'b000, 1, 8'h3C, 0, 1, 3'b100);
    @(negedge clk);
    bus.reti = 1'b0;
    #1;
    checkAll("ext done", 0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000);

    // ext ISR at pc 40, EI inside it, then a timer request
    $display("[TB] sequence: timer during ext isr");
    resetDut();
    @(negedge clk);
    bus.ie_set = 1'b1;
    @(negedge clk);
    bus.ie_set = 1'b0; bus.irq = 1'b1; bus.irq_vec = 3'b100; bus.instr_boundary = 1'b1; bus.pc = 8'h40;
    #1;
    waitTake(4, lat);
    checkOutput("ext entry latency", lat, 1);
    checkOutput("ext entry vec_addr", bus.vec_addr, 8'hF8);
    @(negedge clk);
    bus.irq = 1'b0; bus.pc = 8'h5C; bus.ie_set = 1'b1;
    #1;
    checkOutput("ext ei take_irq", bus.take_irq, 1'b0);
    checkOutput("ext ei in_isr", bus.in_isr, 1'b1);
    @(negedge clk);
    bus.ie_set = 1'b0; bus.irq = 1'b1; bus.irq_vec = 3'b001;
    #1;
    checkOutput("timer arrives take_irq", bus.take_irq, 1'b0);
`ifdef IRQ_NEST_EN
    waitTake(4, lat);
    checkOutput("nested latency", lat, 1);
    checkAll("nested entry", 1, 8'hF0, 3'b001, 0, 8'h00, 1, 1, 3'b100);
    @(negedge clk);
    bus.irq = 1'b0;
    #1;
    checkAll("nested isr", 0, 8'h00, 3'b000, 0, 8'h00, 0, 1, 3'b001);
    @(negedge clk);
    bus.reti = 1'b1;
    #1;
    checkAll("nested reti1", 0, 8'h00, 3'b000, 1, 8'h5C, 0, 1, 3'b001);
    @(negedge clk);
    bus.reti = 1'b0;
    #1;
    checkAll("back in ext", 0, 8'h00, 3'b000, 0, 8'h00, 1, 1, 3'b100);
    @(negedge clk);
    bus.reti = 1'b1;
    #1;
    checkAll("nested reti2", 0, 8'h00, 3'b000, 1, 8'h40, 1, 1, 3'b100);
    @(negedge clk);
    bus.reti = 1'b0;
    #1;
    checkAll("nested done", 0, 8'h00, 3'b000, 0, 8'h00, 1, 0, 3'b000);
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("no nest c%0d take_irq", c), bus.take_irq, 1'b0);
    end
    @(negedge clk);
    bus.reti = 1'b1;
    #1;
    checkAll("flat reti", 0, 8'h00, 3'b000, 1, 8'h40, 1, 1, 3'b100);
    @(negedge clk);
    bus.reti = 1'b0;
    #1;
    waitTake(4, lat);
    checkOutput("timer after reti latency", lat, 1);
    checkOutput("timer after reti vec_addr", bus.vec_addr, 8'hF0);
    checkOutput("timer after reti irq_ack", bus.irq_ack, 3'b001);
`endif

    // asynchronous reset in the middle of an ISR, away from any clock edge
    $display("[TB] sequence: reset mid isr");
    resetDut();
    @(negedge clk);
    bus.ie_set = 1'b1;
    @(negedge clk);
    bus.ie_set = 1'b0; bus.irq = 1'b1; bus.irq_vec = 3'b010; bus.instr_boundary = 1'b1; bus.pc = 8'h66;
    #1;
    waitTake(4, lat);
    checkOutput("uart entry latency", lat, 1);
    @(negedge clk);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0; bus.reti = 1'b1;
    #1;
    checkAll("pre reset", 0, 8'h00, 3'b000, 1, 8'h66, 0, 1, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async reset", 0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
    #1;
    checkAll("after reset", 0, 8'h00, 3'b000, 0, 8'h00, 0, 0, 3'b000);

    // random traffic against the reference model
    $display("[TB] random traffic");
    resetDut();
    modelReset();
    prev_vec = 3'b000;
    for (int c = 0; c < 600; c++) begin
      r_bnd = ($urandom_range(0, 1) == 1);
      r_irq = ($urandom_range(0, 9) < 6);
      rr    = $urandom_range(0, 9);
      r_vec = (rr < 8) ? 3'(3'b001 << (rr % 3)) : ((rr == 8) ? 3'b000 : 3'b110);
      if (m_pend && r_bnd) r_vec = prev_vec;
      r_set  = ($urandom_range(0, 4) == 0);
      r_clr  = ($urandom_range(0, 7) == 0);
      r_reti = ($urandom_range(0, 5) == 0) && !(m_pend && m_stk.size() > 0);
      r_pc   = 8'($urandom_range(0, 255));
      prev_vec = r_vec;
      @(negedge clk);
      bus.irq = r_irq; bus.irq_vec = r_vec; bus.ie_set = r_set; bus.ie_clr = r_clr;
      bus.instr_boundary = r_bnd; bus.pc = r_pc; bus.reti = r_reti;
      #1;
      modelEval(r_irq, r_vec, r_bnd, r_reti);
      checkAll($sformatf("rand%0d", c), e_take, e_addr, e_ack, e_ret, e_rpc, e_ie, e_isr, e_act);
      modelUpdate(r_set, r_clr, r_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
